regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Debug read-out engine sitting on a spare read port (Rs address / read_data pair) of the RISC-V register file. On a start command it walks a programmable index range and streams each register's value, with its index, over a valid/ready output channel toward the debug/trace path. It also accumulates an XOR checksum of the streamed words. It never writes the register file; it is the reader counterpart to the core's writeback path.

## Interface
- NUM_REGS, 32, number of architectural registers; the index wraps modulo NUM_REGS
- ADDR_W, 5, register index width (log2 NUM_REGS)
- DATA_W, 32, register data width
- clk  in  1  rising-edge clock, shared with the register file
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- first_idx  in  ADDR_W  first index to read; sampled with start
- last_idx  in  ADDR_W  final index to read; sampled with start
- abort  in  1  terminate the dump in progress
- rd_addr  out  ADDR_W  drives the register file read address (registered)
- rd_data  in  DATA_W  combinational read data returned for rd_addr
- out_valid  out  1  out_data/out_idx/out_last valid
- out_ready  in  1  downstream accepts the word
- out_data  out  DATA_W  captured register value
- out_idx  out  ADDR_W  index of out_data
- out_last  out  1  high with the final word of the range
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the final word is accepted
- checksum  out  DATA_W  XOR of all words accepted in the current or most recent dump

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE: on start=1, load cur_idx←first_idx, end_idx←last_idx, clear checksum to 0, go to FETCH. A start pulse while busy is ignored.
- FETCH (1 cycle): rd_addr=cur_idx. At the clock edge, capture rd_data into out_data and cur_idx into out_idx. Set out_last=(cur_idx==end_idx) and out_valid=1, then go to SEND.
- SEND: hold out_valid, out_data, out_idx and out_last stable until out_ready=1.
  - On handshake (out_valid&out_ready): checksum←checksum^out_data.
  - If out_last, go to DONE. Otherwise cur_idx←(cur_idx+1) mod NUM_REGS and go to FETCH.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- Range and wrap: the word count is ((last_idx−first_idx) mod NUM_REGS)+1.
  - first_idx==last_idx dumps exactly 1 word.
  - first_idx>last_idx wraps through NUM_REGS−1 to 0, e.g. 30..1 yields 30, 31, 0, 1.
- Abort: when abort=1 in FETCH, SEND or DONE, the next state is IDLE.
  - out_valid falls on that edge and no done pulse is issued.
  - A handshake in the same cycle as abort is still counted in checksum; abort takes priority over the state advance.
  - abort in IDLE is ignored. abort together with start in IDLE: start is ignored.
- Coherency: each word is the register value combinationally present during its FETCH cycle. A same-cycle register file write to that index is not seen, because the file writes at the edge.
- checksum holds its value in IDLE until the next accepted start.

## Timing
- Reset values: state=IDLE, rd_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, checksum=0. rst overrides all other inputs, including mid-dump.
- start sampled at edge N: busy=1 and FETCH during cycle N+1. out_valid=1 from cycle N+2.
- Per word: 1 FETCH cycle plus ≥1 SEND cycle. With out_ready held high, throughput is 1 word per 2 cycles.
- A full 32-register dump with out_ready=1 takes 64 cycles from the first FETCH to the last handshake. done is high in the following cycle and busy falls the cycle after that.
- rd_addr changes only at edges entering FETCH. In IDLE it holds its last value.

## Test plan
- Register file preloaded with reg[i]=3i+1. start with first=0, last=31 and out_ready=1 → 32 words with out_idx 0..31 and out_data 1..94, out_last only on idx 31, done pulse once; checksum equals the XOR of 3i+1 over i=0..31.
- first=5, last=5 → a single word (idx 5, data 16) with out_last=1 and done; checksum=16.
- first=30, last=1 → idx sequence 30, 31, 0, 1 with data 91, 94, 1, 4; out_last on idx 1.
- out_ready low for 7 cycles on word idx 2 of a 0..3 dump → out_valid, out_data=7 and out_idx=2 stay stable throughout; no duplicate or skipped word.
- abort on the second SEND of a 0..31 dump → out_valid=0 and busy=0 the next cycle, no done pulse. checksum reflects only accepted words. A subsequent start works normally.
- rst asserted mid-dump, and start pulsed while busy → all outputs at reset values after rst; a start while busy is ignored and the sequence continues unchanged.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks a register-file index range through a spare read port
// and streams {index, value} over a valid/ready channel while accumulating an XOR checksum.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_idx_i,
    input  logic [ADDR_W-1:0] last_idx_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_idx_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] checksum_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_idx_q, cur_idx_d;
    logic [ADDR_W-1:0]   end_idx_q, end_idx_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;

    logic                handshake;
    logic [ADDR_W-1:0]   next_idx;

    assign handshake = out_valid_q & out_ready_i;
    // The index space wraps at NUM_REGS, which need not be a power of two.
    assign next_idx  = (cur_idx_q == LAST_REG) ? '0 : cur_idx_q + ADDR_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cur_idx_q   <= '0;
            end_idx_q   <= '0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            end_idx_q   <= end_idx_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            checksum_q  <= checksum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        end_idx_d   = end_idx_q;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        checksum_d  = checksum_q;

        unique case (state_q)
            IDLE: begin
                // An abort arriving with start cancels the request outright.
                if (start_i && !abort_i) begin
                    state_d    = FETCH;
                    cur_idx_d  = first_idx_i;
                    end_idx_d  = last_idx_i;
                    rd_addr_d  = first_idx_i;
                    checksum_d = '0;
                end
            end
            FETCH: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    out_data_d  = rd_data_i;
                    out_idx_d   = cur_idx_q;
                    out_last_d  = (cur_idx_q == end_idx_q);
                    out_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // An accepted word always counts, even when abort wins the state decision.
                if (handshake) begin
                    checksum_d = checksum_q ^ out_data_q;
                end
                if (abort_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (handshake) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        cur_idx_d = next_idx;
                        rd_addr_d = next_idx;
                        state_d   = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_addr_o   = rd_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign checksum_o  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: table-driven dumps, hand-written corner
// sequences (stall, abort, reset, start while busy) and randomized dumps against a word-list model.
module tb_regfile_dump_reader;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int TIMEOUT  = 3000;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] first_idx_i;
    logic [ADDR_W-1:0] last_idx_i;
    logic              abort_i;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [ADDR_W-1:0] out_idx_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] checksum_o;

    logic [DATA_W-1:0] regs [NUM_REGS];
    assign rd_data_i = regs[rd_addr_o];

    regfile_dump_reader #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .first_idx_i(first_idx_i),
        .last_idx_i (last_idx_i),
        .abort_i    (abort_i),
        .rd_addr_o  (rd_addr_o),
        .rd_data_i  (rd_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_idx_o  (out_idx_o),
        .out_last_o (out_last_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .checksum_o (checksum_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    // Expected word list for the dump in flight, derived only from the index-range rule.
    int                expIdx[$];
    logic [DATA_W-1:0] expData[$];
    logic [DATA_W-1:0] expChecksum;

    // Words actually accepted on the output channel.
    int                gotIdx[$];
    logic [DATA_W-1:0] gotData[$];
    logic              gotLast[$];
    int                doneCount;
    int                stallCycles;

    int readyMode = 0;
    int stallBudget = 0;

    typedef struct {
        logic [ADDR_W-1:0] first;
        logic [ADDR_W-1:0] last;
        int                expCount;
        logic [DATA_W-1:0] expFirstData;
        logic [DATA_W-1:0] expLastData;
        bit                pokeStart;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Output-channel monitor: records handshakes and checks stability while stalled.
    logic              prevStall = 1'b0;
    logic [DATA_W-1:0] prevData;
    logic [ADDR_W-1:0] prevIdx;
    logic              prevLast;

    always @(negedge clk_i) begin
        if (prevStall) begin
            checkOutput("stall_valid", {31'd0, out_valid_o}, 32'd1);
            checkOutput("stall_data", out_data_o, prevData);
            checkOutput("stall_idx", {27'd0, out_idx_o}, {27'd0, prevIdx});
            checkOutput("stall_last", {31'd0, out_last_o}, {31'd0, prevLast});
        end
        if (!rst_i && out_valid_o && out_ready_i) begin
            gotIdx.push_back(int'(out_idx_o));
            gotData.push_back(out_data_o);
            gotLast.push_back(out_last_o);
        end
        if (!rst_i && out_valid_o && !out_ready_i) stallCycles++;
        if (done_o) doneCount++;
        prevStall = out_valid_o && !out_ready_i && !abort_i && !rst_i;
        prevData  = out_data_o;
        prevIdx   = out_idx_o;
        prevLast  = out_last_o;
    end

    // Downstream ready generator.
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (readyMode)
                0: out_ready_i = 1'b1;
                1: out_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid_o && out_idx_o == 5'd2 && stallBudget > 0) begin
                        out_ready_i = 1'b0;
                        stallBudget--;
                    end else begin
                        out_ready_i = 1'b1;
                    end
                end
                default: out_ready_i = 1'b1;
            endcase
        end
    end

    task automatic preloadRegs();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'(3 * i + 1);
    endtask

    task automatic pulseReset();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // Builds the expected word list, pulses start, and checks the first two cycles.
    task automatic applyStimulus(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
        int cnt;
        int idx;
        expIdx.delete();
        expData.delete();
        gotIdx.delete();
        gotData.delete();
        gotLast.delete();
        doneCount   = 0;
        stallCycles = 0;
        expChecksum = '0;
        cnt = ((int'(l) - int'(f) + NUM_REGS) % NUM_REGS) + 1;
        for (int k = 0; k < cnt; k++) begin
            idx = (int'(f) + k) % NUM_REGS;
            expIdx.push_back(idx);
            expData.push_back(regs[idx]);
            expChecksum = expChecksum ^ regs[idx];
        end
        @(posedge clk_i);
        #1;
        start_i     = 1'b1;
        first_idx_i = f;
        last_idx_i  = l;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        first_idx_i = 5'($urandom_range(0, 31));
        last_idx_i  = 5'($urandom_range(0, 31));
        @(negedge clk_i);
        checkOutput("fetch_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("fetch_rd_addr", {27'd0, rd_addr_o}, {27'd0, f});
        checkOutput("fetch_valid_low", {31'd0, out_valid_o}, 32'd0);
        @(negedge clk_i);
        checkOutput("first_valid", {31'd0, out_valid_o}, 32'd1);
        checkOutput("first_idx", {27'd0, out_idx_o}, {27'd0, f});
        checkOutput("first_data", out_data_o, regs[f]);
    endtask

    task automatic waitDone(input bit poke, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int c = 0; c < TIMEOUT; c++) begin
            if (poke && c == 4) begin
                start_i     = 1'b1;
                first_idx_i = 5'd20;
                last_idx_i  = 5'd21;
            end
            if (poke && c == 5) start_i = 1'b0;
            @(negedge clk_i);
            cycles++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        if (!seen) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            pulseReset();
        end
    endtask

    // Compares the accepted words and end-of-dump state against the model.
    task automatic verifyDump();
        int n;
        n = (gotIdx.size() < expIdx.size()) ? gotIdx.size() : expIdx.size();
        checkOutput("word_count", 32'(gotIdx.size()), 32'(expIdx.size()));
        for (int k = 0; k < n; k++) begin
            checkOutput("word_idx", 32'(gotIdx[k]), 32'(expIdx[k]));
            checkOutput("word_data", gotData[k], expData[k]);
            checkOutput("word_last", {31'd0, gotLast[k]}, (k == expIdx.size() - 1) ? 32'd1 : 32'd0);
        end
        checkOutput("checksum", checksum_o, expChecksum);
        @(negedge clk_i);
        checkOutput("done_count", 32'(doneCount), 32'd1);
        checkOutput("busy_fall", {31'd0, busy_o}, 32'd0);
        checkOutput("done_low", {31'd0, done_o}, 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rd_addr"}, {27'd0, rd_addr_o}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
        checkOutput({tag, "_data"}, out_data_o, 32'd0);
        checkOutput({tag, "_idx"}, {27'd0, out_idx_o}, 32'd0);
        checkOutput({tag, "_last"}, {31'd0, out_last_o}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done_o}, 32'd0);
        checkOutput({tag, "_checksum"}, checksum_o, 32'd0);
    endtask

    initial begin
        int cycles;
        logic [ADDR_W-1:0] rf;
        logic [ADDR_W-1:0] rl;

        vecs[0] = '{5'd0,  5'd31, 32, 32'd1,  32'd94, 1'b0};
        vecs[1] = '{5'd5,  5'd5,  1,  32'd16, 32'd16, 1'b0};
        vecs[2] = '{5'd30, 5'd1,  4,  32'd91, 32'd4,  1'b0};
        vecs[3] = '{5'd0,  5'd7,  8,  32'd1,  32'd22, 1'b1};
        vecs[4] = '{5'd31, 5'd0,  2,  32'd94, 32'd1,  1'b0};

        rst_i       = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        first_idx_i = '0;
        last_idx_i  = '0;
        preloadRegs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkResetState("reset");
        #1 rst_i = 1'b0;

        // Table-driven dumps with out_ready held high.
        readyMode = 0;
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].first, vecs[v].last);
            waitDone(vecs[v].pokeStart, cycles);
            checkOutput("tbl_count", 32'(gotIdx.size()), 32'(vecs[v].expCount));
            if (gotData.size() > 0) begin
                checkOutput("tbl_first_data", gotData[0], vecs[v].expFirstData);
                checkOutput("tbl_last_data", gotData[gotData.size() - 1], vecs[v].expLastData);
            end
            checkOutput("tbl_cycles", 32'(cycles), 32'(2 * vecs[v].expCount - 1));
            verifyDump();
        end

        // Seven-cycle stall on idx 2 of a 0..3 dump.
        readyMode   = 2;
        stallBudget = 7;
        applyStimulus(5'd0, 5'd3);
        waitDone(1'b0, cycles);
        checkOutput("stall_cycles", 32'(stallCycles), 32'd7);
        if (gotData.size() > 2) checkOutput("stall_word2", gotData[2], 32'd7);
        verifyDump();
        readyMode = 0;

        // Abort on the second SEND of a full dump; the accepted word still counts.
        applyStimulus(5'd0, 5'd31);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 abort_i = 1'b1;
        @(posedge clk_i);
        #1 abort_i = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("abort_words", 32'(gotIdx.size()), 32'd2);
        checkOutput("abort_checksum", checksum_o, regs[0] ^ regs[1]);
        repeat (4) @(negedge clk_i);
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        checkOutput("abort_checksum_hold", checksum_o, regs[0] ^ regs[1]);

        // A fresh dump after the abort behaves normally.
        applyStimulus(5'd5, 5'd5);
        waitDone(1'b0, cycles);
        verifyDump();

        // Reset mid-dump, then start together with abort in IDLE.
        applyStimulus(5'd0, 5'd31);
        repeat (5) @(negedge clk_i);
        pulseReset();
        @(negedge clk_i);
        checkResetState("midrst");
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        @(negedge clk_i);
        checkOutput("start_abort_busy", {31'd0, busy_o}, 32'd0);

        // Randomized register contents, ranges and backpressure.
        readyMode = 1;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
        for (int t = 0; t < 12; t++) begin
            rf = 5'($urandom_range(0, 31));
            rl = 5'($urandom_range(0, 31));
            applyStimulus(rf, rl);
            waitDone(1'b0, cycles);
            verifyDump();
        end
        readyMode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
